// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller:
// FSM state encoding, register-index and statistics widths.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    FAULT    = 2'b10
  } hz_state_t;

  localparam int REG_IDX_W = 3;
  localparam logic [REG_IDX_W-1:0] REG_ZERO = 3'b000;

  localparam int STAT_W = 16;
  localparam logic [STAT_W-1:0] STAT_MAX = 16'hFFFF;

  localparam int WAIT_W = 8;

  // r0 is hard-wired zero, so a write to it never creates a true dependency.
  function automatic logic reg_dep(input logic [REG_IDX_W-1:0] dst,
                                   input logic [REG_IDX_W-1:0] src);
    return (dst != REG_ZERO) && (dst == src);
  endfunction

endpackage

// File: rtl/hazard_stat_counter.sv
// Saturating event counter used for the hazard statistics; holds at all-ones
// rather than wrapping so a long run never reports a misleadingly small value.
module hazard_stat_counter
  import hazard_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  output logic [STAT_W-1:0] count
);

  logic [STAT_W-1:0] count_r;

  // count register: clear on reset, step on inc until saturated
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {STAT_W{1'b0}};
    end else if (inc && (count_r != STAT_MAX)) begin
      count_r <= count_r + 16'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: load-use stalls, branch flushes and memory waits
// with a sticky timeout fault. Optional statistics under HAZARD_STATS_EN.
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 PR3_MEM_read,
  input  logic                 PR3_MEM_write,
  input  logic                 PR3_RF_write_en,
  input  logic [REG_IDX_W-1:0] PR3_rd,
  input  logic [REG_IDX_W-1:0] PR2_rs,
  input  logic [REG_IDX_W-1:0] PR2_rt,
  input  logic                 branch_taken,
  input  logic                 mem_ready,
  output logic                 PC_write_en,
  output logic                 PR1_write_en,
  output logic                 PR2_write_en,
  output logic                 PR3_write_en,
  output logic                 PR4_write_en,
  output logic                 PR1_flush,
  output logic                 PR2_flush,
  output logic                 PR3_bubble,
  output logic                 mem_fault,
  output logic [STAT_W-1:0]    load_stall_count,
  output logic [STAT_W-1:0]    mem_stall_count,
  output logic [STAT_W-1:0]    flush_count
);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  hz_state_t         state_r;
  hz_state_t         state_next_s;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic [WAIT_W-1:0] wait_cnt_next_s;
  logic              mem_stall_s;
  logic              load_use_s;

  // hazard detection from the PR3 / PR2 stage contents
  always_comb begin
    mem_stall_s = (PR3_MEM_read | PR3_MEM_write) & ~mem_ready;
    load_use_s  = PR3_MEM_read & PR3_RF_write_en &
                  (reg_dep(PR3_rd, PR2_rs) | reg_dep(PR3_rd, PR2_rt));
  end

  // next state, wait counter and stage controls in priority order
  always_comb begin
    PC_write_en     = 1'b0;
    PR1_write_en    = 1'b0;
    PR2_write_en    = 1'b0;
    PR3_write_en    = 1'b0;
    PR4_write_en    = 1'b0;
    PR1_flush       = 1'b0;
    PR2_flush       = 1'b0;
    PR3_bubble      = 1'b0;
    mem_fault       = 1'b0;
    state_next_s    = state_r;
    wait_cnt_next_s = {WAIT_W{1'b0}};
    if (rst) begin
      state_next_s = RUN;
    end else begin
      case (state_r)
        RUN, MEM_WAIT: begin
          if (mem_stall_s) begin
            // whole pipeline frozen; other hazards are re-seen after release
            wait_cnt_next_s = wait_cnt_r + 8'd1;
            if (wait_cnt_r == WAIT_LAST) begin
              state_next_s = FAULT;
            end else begin
              state_next_s = MEM_WAIT;
            end
          end else if (load_use_s) begin
            PR3_write_en = 1'b1;
            PR4_write_en = 1'b1;
            PR3_bubble   = 1'b1;
            state_next_s = RUN;
          end else if (branch_taken) begin
            PC_write_en  = 1'b1;
            PR1_write_en = 1'b1;
            PR2_write_en = 1'b1;
            PR3_write_en = 1'b1;
            PR4_write_en = 1'b1;
            PR1_flush    = 1'b1;
            PR2_flush    = 1'b1;
            state_next_s = RUN;
          end else begin
            PC_write_en  = 1'b1;
            PR1_write_en = 1'b1;
            PR2_write_en = 1'b1;
            PR3_write_en = 1'b1;
            PR4_write_en = 1'b1;
            state_next_s = RUN;
          end
        end
        FAULT: begin
          mem_fault    = 1'b1;
          state_next_s = FAULT;
        end
        default: begin
          state_next_s = RUN;
        end
      endcase
    end
  end

  // state and wait-counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= RUN;
      wait_cnt_r <= {WAIT_W{1'b0}};
    end else begin
      state_r    <= state_next_s;
      wait_cnt_r <= wait_cnt_next_s;
    end
  end

`ifdef HAZARD_STATS_EN
  logic              load_stall_evt_s;
  logic              mem_stall_evt_s;
  logic              flush_evt_s;
  logic [STAT_W-1:0] load_stall_cnt_s;
  logic [STAT_W-1:0] mem_stall_cnt_s;
  logic [STAT_W-1:0] flush_cnt_s;

  // events are taken from the resolved controls so they follow the same priority
  assign load_stall_evt_s = PR3_bubble;
  assign flush_evt_s      = PR1_flush;
  assign mem_stall_evt_s  = ~rst & mem_stall_s &
                            ((state_r == RUN) | (state_r == MEM_WAIT));

  hazard_stat_counter u_load_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (load_stall_evt_s),
    .count (load_stall_cnt_s)
  );

  hazard_stat_counter u_mem_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (mem_stall_evt_s),
    .count (mem_stall_cnt_s)
  );

  hazard_stat_counter u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_evt_s),
    .count (flush_cnt_s)
  );

  assign load_stall_count = rst ? {STAT_W{1'b0}} : load_stall_cnt_s;
  assign mem_stall_count  = rst ? {STAT_W{1'b0}} : mem_stall_cnt_s;
  assign flush_count      = rst ? {STAT_W{1'b0}} : flush_cnt_s;
`else
  assign load_stall_count = {STAT_W{1'b0}};
  assign mem_stall_count  = {STAT_W{1'b0}};
  assign flush_count      = {STAT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed-vector bench for hazard_control_unit with a cycle-level reference
// model of the hazard rules and hand-computed expectations per vector.
module tb_hazard_control_unit;

  localparam int unsigned TMO = 4;

`ifdef HAZARD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  // control vector: {PC,PR1,PR2,PR3,PR4 write_en, PR1_flush, PR2_flush, PR3_bubble, mem_fault}
  localparam logic [8:0] C_RST  = 9'b00000_000_0;
  localparam logic [8:0] C_NORM = 9'b11111_000_0;
  localparam logic [8:0] C_BR   = 9'b11111_110_0;
  localparam logic [8:0] C_LU   = 9'b00011_001_0;
  localparam logic [8:0] C_FRZ  = 9'b00000_000_0;
  localparam logic [8:0] C_FLT  = 9'b00000_000_1;

  typedef struct {
    bit       rst, mr, mw, we;
    bit [2:0] rd, rs, rt;
    bit       br, rdy;
    bit [8:0] exp;
    bit       chk;
    int       ld, ms, fl;
  } vec_t;

  logic clk = 1'b1;
  logic rst, PR3_MEM_read, PR3_MEM_write, PR3_RF_write_en;
  logic [2:0] PR3_rd, PR2_rs, PR2_rt;
  logic branch_taken, mem_ready;
  logic PC_write_en, PR1_write_en, PR2_write_en, PR3_write_en, PR4_write_en;
  logic PR1_flush, PR2_flush, PR3_bubble, mem_fault;
  logic [15:0] load_stall_count, mem_stall_count, flush_count;

  vec_t vecs[$];
  vec_t cur;
  int   cur_row = 0;
  bit   chk_on = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  // reference model state
  bit m_fault = 1'b0;
  int m_run = 0;
  int m_ld = 0, m_ms = 0, m_fl = 0;

  always #5 clk = ~clk;

  hazard_control_unit #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .PR3_MEM_read(PR3_MEM_read), .PR3_MEM_write(PR3_MEM_write),
    .PR3_RF_write_en(PR3_RF_write_en), .PR3_rd(PR3_rd),
    .PR2_rs(PR2_rs), .PR2_rt(PR2_rt),
    .branch_taken(branch_taken), .mem_ready(mem_ready),
    .PC_write_en(PC_write_en), .PR1_write_en(PR1_write_en),
    .PR2_write_en(PR2_write_en), .PR3_write_en(PR3_write_en),
    .PR4_write_en(PR4_write_en), .PR1_flush(PR1_flush), .PR2_flush(PR2_flush),
    .PR3_bubble(PR3_bubble), .mem_fault(mem_fault),
    .load_stall_count(load_stall_count), .mem_stall_count(mem_stall_count),
    .flush_count(flush_count)
  );

  function automatic bit m_stall(input vec_t v);
    return (v.mr || v.mw) && !v.rdy;
  endfunction

  function automatic bit m_loaduse(input vec_t v);
    return v.mr && v.we && (v.rd != 3'd0) && (v.rd == v.rs || v.rd == v.rt);
  endfunction

  // expected controls from the rule list, highest priority first
  function automatic logic [8:0] m_ctrl(input vec_t v, input bit fault);
    if (v.rst)             return 9'b00000_000_0;
    if (fault)             return 9'b00000_000_1;
    if (m_stall(v))        return 9'b00000_000_0;
    if (m_loaduse(v))      return 9'b00011_001_0;
    if (v.br)              return 9'b11111_110_0;
    return 9'b11111_000_0;
  endfunction

  function automatic logic [15:0] m_cnt(input int c, input bit in_rst);
    if (!STATS || in_rst) return 16'd0;
    return 16'(c);
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s row=%0d actual=%h required=%h", name, cur_row, act, req);
    end
  endtask

  task automatic v(input bit r, input bit mr, input bit mw, input bit we,
                   input bit [2:0] rd, input bit [2:0] rs, input bit [2:0] rt,
                   input bit br, input bit rdy, input bit [8:0] exp);
    vec_t t;
    t.rst = r; t.mr = mr; t.mw = mw; t.we = we;
    t.rd = rd; t.rs = rs; t.rt = rt; t.br = br; t.rdy = rdy;
    t.exp = exp; t.chk = 1'b0; t.ld = 0; t.ms = 0; t.fl = 0;
    vecs.push_back(t);
  endtask

  task automatic mark(input int ld, input int ms, input int fl);
    vec_t t;
    t = vecs.pop_back();
    t.chk = 1'b1; t.ld = ld; t.ms = ms; t.fl = fl;
    vecs.push_back(t);
  endtask

  task automatic apply(input vec_t t);
    rst = t.rst; PR3_MEM_read = t.mr; PR3_MEM_write = t.mw;
    PR3_RF_write_en = t.we; PR3_rd = t.rd; PR2_rs = t.rs; PR2_rt = t.rt;
    branch_taken = t.br; mem_ready = t.rdy;
  endtask

  // model state advances on the same edge as the DUT, using the inputs of that cycle
  always @(posedge clk) begin
    if (chk_on) begin
      if (cur.rst) begin
        m_fault = 1'b0; m_run = 0; m_ld = 0; m_ms = 0; m_fl = 0;
      end else if (m_fault) begin
        m_run = 0;
      end else if (m_stall(cur)) begin
        m_run++;
        if (m_ms < 65535) m_ms++;
        if (m_run == int'(TMO)) begin
          m_fault = 1'b1;
          m_run = 0;
        end
      end else begin
        m_run = 0;
        if (m_loaduse(cur)) begin
          if (m_ld < 65535) m_ld++;
        end else if (cur.br) begin
          if (m_fl < 65535) m_fl++;
        end
      end
    end
  end

  // compare process: DUT against model every cycle, model against hand values
  always @(negedge clk) begin
    if (chk_on) begin
      logic [8:0] dut_ctrl;
      logic [8:0] mod_ctrl;
      dut_ctrl = {PC_write_en, PR1_write_en, PR2_write_en, PR3_write_en, PR4_write_en,
                  PR1_flush, PR2_flush, PR3_bubble, mem_fault};
      mod_ctrl = m_ctrl(cur, m_fault);
      check("ctrl", {7'd0, dut_ctrl}, {7'd0, mod_ctrl});
      check("model_ctrl", {7'd0, mod_ctrl}, {7'd0, cur.exp});
      check("load_stall_count", load_stall_count, m_cnt(m_ld, cur.rst));
      check("mem_stall_count", mem_stall_count, m_cnt(m_ms, cur.rst));
      check("flush_count", flush_count, m_cnt(m_fl, cur.rst));
      if (cur.chk) begin
        check("model_ld", m_cnt(m_ld, cur.rst), m_cnt(cur.ld, 1'b0));
        check("model_ms", m_cnt(m_ms, cur.rst), m_cnt(cur.ms, 1'b0));
        check("model_fl", m_cnt(m_fl, cur.rst), m_cnt(cur.fl, 1'b0));
      end
    end
  end

  initial begin
    //  rst mr mw we rd rs rt br rdy  expected
    v(1, 0, 0, 0, 0, 0, 0, 0, 0, C_RST);
    v(1, 0, 0, 0, 0, 0, 0, 0, 0, C_RST);
    v(0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORM);   // mem_ready low, no op
    v(0, 1, 0, 1, 3, 3, 0, 0, 1, C_LU);     // load r3, rs=3
    v(0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORM); mark(1, 0, 0);
    v(0, 1, 0, 1, 0, 0, 0, 0, 1, C_NORM);   // load r0
    v(0, 0, 1, 0, 2, 1, 2, 0, 1, C_NORM);   // store, rd matches rt
    v(0, 1, 0, 0, 5, 0, 5, 0, 1, C_NORM);   // load without RF write
    v(0, 0, 0, 0, 0, 0, 0, 1, 1, C_BR);
    v(0, 1, 0, 1, 4, 1, 4, 1, 1, C_LU);     // load-use beats branch
    v(0, 1, 0, 1, 6, 1, 2, 0, 0, C_FRZ);
    v(0, 1, 0, 1, 6, 1, 2, 0, 0, C_FRZ);
    v(0, 1, 0, 1, 6, 1, 2, 0, 0, C_FRZ);    // TMO-1 stalls: still no fault
    v(0, 1, 0, 1, 6, 1, 2, 0, 1, C_NORM); mark(2, 3, 1);
    v(0, 1, 0, 1, 6, 6, 0, 1, 0, C_FRZ);    // stall beats load-use and branch
    v(0, 1, 0, 1, 6, 6, 0, 1, 1, C_LU);     // re-evaluated after release
    v(0, 0, 0, 0, 0, 0, 0, 0, 1, C_NORM);
    v(0, 0, 0, 0, 0, 0, 0, 1, 0, C_BR);
    for (int i = 0; i < 4; i++) v(0, 0, 1, 0, 1, 1, 1, 0, 0, C_FRZ);
    v(0, 0, 1, 0, 1, 1, 1, 0, 0, C_FLT);    // cycle TMO: fault
    v(0, 0, 0, 0, 0, 0, 0, 1, 1, C_FLT);
    v(0, 0, 0, 0, 0, 0, 0, 0, 0, C_FLT); mark(3, 8, 2);
    v(1, 0, 1, 0, 1, 1, 1, 0, 0, C_RST);
    v(0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORM); mark(0, 0, 0);
    for (int i = 0; i < 3; i++) v(0, 0, 1, 0, 1, 0, 0, 0, 0, C_FRZ);
    v(1, 0, 1, 0, 1, 0, 0, 0, 0, C_RST);    // reset drops the pending wait
    for (int i = 0; i < 3; i++) v(0, 0, 1, 0, 1, 0, 0, 0, 0, C_FRZ);
    v(0, 0, 1, 0, 1, 0, 0, 0, 1, C_NORM);
    v(0, 1, 0, 1, 7, 0, 7, 0, 1, C_LU);
    v(0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORM); mark(1, 3, 0);

    cur = vecs[0];
    cur_row = 0;
    apply(cur);
    chk_on = 1'b1;
    for (int i = 1; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      cur = vecs[i];
      cur_row = i;
      apply(cur);
    end
    @(posedge clk);
    #1;
    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_control_unit.md
# hazard_control_unit

Pipeline hazard controller for the 5-stage, 8-register core. It sits beside the EX-stage forwarding logic and drives the write-enable, flush and bubble controls of the PC and pipeline registers PR1 (IF/ID) through PR4 (MEM/WB). It covers three cases: load-use stalls that forwarding cannot resolve, taken-branch flushes, and variable-latency data-memory waits, with a timeout to a sticky fault state.

## Interface
Parameters:
- MEM_TIMEOUT, 64: consecutive memory-stall cycles allowed before FAULT; legal range 1..255.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- PR3_MEM_read  in  1  instruction in PR3 is a load.
- PR3_MEM_write  in  1  instruction in PR3 is a store.
- PR3_RF_write_en  in  1  instruction in PR3 writes the register file.
- PR3_rd  in  3  destination register of the PR3 instruction.
- PR2_rs, PR2_rt  in  3 each  source registers of the EX-stage instruction.
- branch_taken  in  1  EX-stage branch resolved taken.
- mem_ready  in  1  data memory completes the PR3 access this cycle.
- PC_write_en, PR1_write_en, PR2_write_en, PR3_write_en, PR4_write_en  out  1 each  stage register load enables.
- PR1_flush, PR2_flush  out  1 each  load NOP into PR1 or PR2 at the next edge.
- PR3_bubble  out  1  load NOP into PR3 at the next edge.
- mem_fault  out  1  sticky memory-timeout fault.
- load_stall_count, mem_stall_count, flush_count  out  16 each  statistics, see Configuration.

## Operation
- FSM states: RUN, MEM_WAIT, FAULT. Control outputs are combinational from the state and the current inputs.
- mem_stall = (PR3_MEM_read | PR3_MEM_write) & ~mem_ready, evaluated in RUN or MEM_WAIT.
- load_use = PR3_MEM_read & PR3_RF_write_en & PR3_rd != 0 & (PR3_rd == PR2_rs | PR3_rd == PR2_rt).
- Priority order: rst > FAULT > mem_stall > load_use > branch_taken > normal.
- FAULT: all enables 0, all flush/bubble outputs 0, mem_fault = 1. The state is left only by rst.
- mem_stall: all five enables 0 and no flush or bubble, so the whole pipeline freezes. branch_taken and load_use are ignored this cycle; they are re-evaluated once the freeze ends because the stage contents are held.
- load_use: PC, PR1 and PR2 hold (enables 0). PR3_write_en = 1 with PR3_bubble = 1. PR4_write_en = 1.
- branch_taken: all enables 1, PR1_flush = 1, PR2_flush = 1.
- normal: all enables 1, no flush or bubble.
- wait_cnt (8 bits):
  - Increments in every mem_stall cycle.
  - Clears in any cycle without mem_stall.
  - Resets to 0.
- Transitions:
  - RUN → MEM_WAIT on mem_stall.
  - MEM_WAIT → RUN in the first cycle with mem_ready = 1; the pipeline advances in that cycle.
  - RUN or MEM_WAIT → FAULT when mem_stall holds and wait_cnt == MEM_TIMEOUT − 1, i.e. on the MEM_TIMEOUT-th consecutive stall cycle.

## Timing
- Zero-cycle latency: control outputs respond to inputs in the same cycle.
- Reset values, with rst = 1 in a cycle: all enables 0, flush/bubble outputs 0, mem_fault 0, statistics 0. After the edge: state = RUN, wait_cnt = 0.
- rst asserted in MEM_WAIT or FAULT returns to RUN at the next edge. No pending wait is remembered.
- A load-use stall lasts exactly 1 cycle, because the load moves to PR4 at the next edge.
- mem_fault rises in the first cycle spent in FAULT: with MEM_TIMEOUT = 4, stalls in cycles 0–3, then FAULT and mem_fault = 1 in cycle 4.
- mem_ready = 1 in a cycle with no memory op in PR3 has no effect.

## Configuration
- HAZARD_STATS_EN defined: three 16-bit saturating counters, each stopping at 16'hFFFF.
  - load_stall_count increments per load_use stall cycle.
  - mem_stall_count increments per mem_stall cycle.
  - flush_count increments per branch flush cycle.
  - The counters cleared by rst and frozen in FAULT.
- HAZARD_STATS_EN undefined: the three ports remain and are driven constant 0, with no counter flops.

## Structure
- hazard_pkg holds:
  - the state enum: hz_state_t {RUN, MEM_WAIT, FAULT}.
  - REG_IDX_W = 3 and REG_ZERO = 3'b000.
  - STAT_W = 16.
- One sub-module, hazard_stat_counter, is a STAT_W-bit saturating counter with inc and rst. It is instantiated three times, only under HAZARD_STATS_EN.

## Test plan
- Load r3 in PR3, PR2_rs = 3, mem_ready = 1 → one cycle: PC/PR1/PR2 enables = 0, PR3_bubble = 1, PR4_write_en = 1. Next cycle normal. load_stall_count = 1.
- Load r0 in PR3, PR2_rs = 0 → no stall. Store in PR3 with matching rd → no load-use stall.
- branch_taken = 1, no hazards → all enables 1, PR1_flush = PR2_flush = 1 for that cycle. flush_count increments.
- Load in PR3 with mem_ready low for 3 cycles, MEM_TIMEOUT = 64 → 3 cycles all enables 0, state MEM_WAIT. The 4th cycle advances and returns to RUN. mem_stall_count = 3.
- MEM_TIMEOUT = 4, store in PR3, mem_ready held 0 → FAULT from cycle 4 with mem_fault = 1 and enables 0. rst → RUN next edge, mem_fault = 0.
- load_use and branch_taken together → load-use response, no flush. mem_stall and load_use together → full freeze only.
